// File: rtl/mod_scalar_mul_ctrl.sv
// mod_scalar_mul_ctrl
// Computes result = (k * a) mod m with MSB-first double-and-add, issuing every
// double (acc+acc) and add (acc+a) to the downstream modular adder through its
// start/done handshake. All modular reduction happens inside the adder.
// Optional feature macro: MOD_SCALAR_SKIP_LZ_EN. When defined, the scan starts
// at the leading one of k and the first set bit loads acc<=a without an adder
// request, so leading zero bits cost nothing.
module mod_scalar_mul_ctrl #(
  parameter int N_WIDTH = 381,
  parameter int K_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_WIDTH-1:0] in_a,
  input  logic [N_WIDTH-1:0] in_m,
  input  logic [K_WIDTH-1:0] in_k,
  output logic               busy,
  output logic               done,
  output logic [N_WIDTH-1:0] result,
  output logic               add_start,
  output logic               add_subtract,
  output logic [N_WIDTH-1:0] add_a,
  output logic [N_WIDTH-1:0] add_b,
  output logic [N_WIDTH-1:0] add_m,
  input  logic [N_WIDTH-1:0] add_result,
  input  logic               add_done
);

  localparam int IW = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DBL_REQ,
    ST_DBL_WAIT,
    ST_ADD_REQ,
    ST_ADD_WAIT,
    ST_NEXT,
    ST_FIN
  } state_t;

  state_t             r_state, w_state_next;
  logic [N_WIDTH-1:0] r_acc, w_acc_next;
  logic [N_WIDTH-1:0] r_a, w_a_next;
  logic [N_WIDTH-1:0] r_m, w_m_next;
  logic [K_WIDTH-1:0] r_k, w_k_next;
  logic [IW-1:0]      r_i, w_i_next;
  logic [N_WIDTH-1:0] r_result, w_result_next;
  logic [N_WIDTH-1:0] r_add_a, r_add_b, r_add_m;
  logic               w_req;

`ifdef MOD_SCALAR_SKIP_LZ_EN
  // r_lz: acc is still known to be zero (no set bit of k consumed yet)
  logic               r_lz, w_lz_next;
  logic [IW-1:0]      w_lead_idx;

  // Index of the most significant set bit of in_k (0 when in_k is zero)
  always_comb begin
    w_lead_idx = '0;
    for (int j = 0; j < K_WIDTH; j++) begin
      if (in_k[j]) w_lead_idx = IW'(j);
    end
  end
`endif

  // Next-state and datapath-next logic of the double-and-add sequencer
  always_comb begin
    w_state_next  = r_state;
    w_acc_next    = r_acc;
    w_a_next      = r_a;
    w_m_next      = r_m;
    w_k_next      = r_k;
    w_i_next      = r_i;
    w_result_next = r_result;
`ifdef MOD_SCALAR_SKIP_LZ_EN
    w_lz_next     = r_lz;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_a_next     = in_a;
          w_m_next     = in_m;
          w_k_next     = in_k;
          w_acc_next   = '0;
`ifdef MOD_SCALAR_SKIP_LZ_EN
          w_i_next     = w_lead_idx;
          w_lz_next    = 1'b1;
`else
          w_i_next     = IW'(K_WIDTH - 1);
`endif
          w_state_next = ST_DBL_REQ;
        end
      end
      ST_DBL_REQ: begin
`ifdef MOD_SCALAR_SKIP_LZ_EN
        // Doubling zero is pointless; the first set bit simply loads a
        if (r_lz) begin
          if (r_k[r_i]) begin
            w_acc_next = r_a;
            w_lz_next  = 1'b0;
          end
          w_state_next = ST_NEXT;
        end else begin
          w_state_next = ST_DBL_WAIT;
        end
`else
        w_state_next = ST_DBL_WAIT;
`endif
      end
      ST_DBL_WAIT: begin
        if (add_done) begin
          w_acc_next   = add_result;
          w_state_next = r_k[r_i] ? ST_ADD_REQ : ST_NEXT;
        end
      end
      ST_ADD_REQ: begin
        w_state_next = ST_ADD_WAIT;
      end
      ST_ADD_WAIT: begin
        if (add_done) begin
          w_acc_next   = add_result;
          w_state_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (r_i == '0) begin
          w_result_next = r_acc;
          w_state_next  = ST_FIN;
        end else begin
          w_i_next     = r_i - 1'b1;
          w_state_next = ST_DBL_REQ;
        end
      end
      ST_FIN: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_a      <= '0;
      r_m      <= '0;
      r_k      <= '0;
      r_i      <= '0;
      r_result <= '0;
`ifdef MOD_SCALAR_SKIP_LZ_EN
      r_lz     <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_acc    <= w_acc_next;
      r_a      <= w_a_next;
      r_m      <= w_m_next;
      r_k      <= w_k_next;
      r_i      <= w_i_next;
      r_result <= w_result_next;
`ifdef MOD_SCALAR_SKIP_LZ_EN
      r_lz     <= w_lz_next;
`endif
    end
  end

  // Adder operands are loaded on entry to a request state and then held
  // untouched until the next request, so they stay stable through add_done
  always_ff @(posedge clk) begin
    if (reset) begin
      r_add_a <= '0;
      r_add_b <= '0;
      r_add_m <= '0;
    end else if (w_state_next == ST_DBL_REQ) begin
      r_add_a <= w_acc_next;
      r_add_b <= w_acc_next;
      r_add_m <= w_m_next;
    end else if (w_state_next == ST_ADD_REQ) begin
      r_add_a <= w_acc_next;
      r_add_b <= r_a;
    end
  end

`ifdef MOD_SCALAR_SKIP_LZ_EN
  assign w_req = ((r_state == ST_DBL_REQ) && !r_lz) || (r_state == ST_ADD_REQ);
`else
  assign w_req = (r_state == ST_DBL_REQ) || (r_state == ST_ADD_REQ);
`endif

  assign add_start    = w_req;
  assign add_subtract = 1'b0;
  assign add_a        = r_add_a;
  assign add_b        = r_add_b;
  assign add_m        = r_add_m;
  assign busy         = (r_state != ST_IDLE) && (r_state != ST_FIN);
  assign done         = (r_state == ST_FIN);
  assign result       = r_result;

endmodule
